fc_core_scheduler: RTL and testbench
====================================

FC_CORE_SCHEDULER -- requirements
Module: fc_core_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of requesting cores (2..8).
REQ-002 SHALL have parameter N_TAPS, default 9, number of MAC terms per evaluation.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req  in  NUM_CORES  bit i high: core i requests one FC evaluation.
REQ-006 SHALL have port in_valid  in  NUM_CORES  bit i high: core i presents an input sample.
REQ-007 SHALL have port in_data  in  NUM_CORES*8  signed 8-bit sample of core i at bits [8i+7:8i].
REQ-008 SHALL have port in_ready  out  NUM_CORES  one-hot or zero; high only for the granted core during MAC.
REQ-009 SHALL have port gnt  out  NUM_CORES  one-hot grant; zero when no evaluation is in progress.
REQ-010 SHALL have port cfg_we  in  1  write strobe for the weight/bias table.
REQ-011 SHALL have port cfg_addr  in  4  address 0..N_TAPS-1 selects a weight; N_TAPS selects bias.
REQ-012 SHALL have port cfg_wdata  in  8  signed weight or bias value.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse when a write is rejected.
REQ-014 SHALL have port res_valid  out  1  result available.
REQ-015 SHALL have port res_ready  in  1  consumer accepts the result.
REQ-016 SHALL have port res_data  out  16  signed saturated FC result.
REQ-017 SHALL have port res_core  out  3  index of the core that owns res_data.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, MAC, BIAS, OUT.
REQ-020 IDLE: if req != 0, SHALL pick a winner round-robin starting at pointer rr_ptr, assert gnt for it on the next cycle, clear the accumulator and tap index, and move to MAC.
REQ-021 MAC: in_ready SHALL equal gnt; each cycle with in_valid[g] && in_ready[g] SHALL add in_data[g]*w[idx] to the accumulator and increment idx.
REQ-022 MAC: cycles without in_valid[g] SHALL stall with no state change; there is no timeout.
REQ-023 After the N_TAPS-th handshake SHALL move to BIAS; in_ready SHALL drop in the following cycle.
REQ-024 BIAS: SHALL add the sign-extended bias in one cycle and move to OUT.
REQ-025 Accumulator SHALL be 20-bit signed (no overflow possible); products SHALL be full 16-bit signed.
REQ-026 res_data SHALL be the accumulator saturated to [-32768, 32767].
REQ-027 OUT: res_valid SHALL be high with res_data, res_core stable until res_valid && res_ready; that cycle SHALL set rr_ptr to g+1 (wrapping NUM_CORES-1 -> 0), clear gnt, and return to IDLE.
REQ-028 Latency: req in IDLE at cycle t with continuous in_valid SHALL give res_valid at t+N_TAPS+2.
REQ-029 req changes after the grant SHALL NOT affect the running evaluation; req of non-granted cores SHALL be held off, not dropped.
REQ-030 cfg writes SHALL take effect only in IDLE; writes outside IDLE or to cfg_addr > N_TAPS SHALL be ignored and pulse cfg_err the next cycle.
REQ-031 A cfg write and a new grant in the same IDLE cycle SHALL both occur; the evaluation SHALL use the newly written value.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, gnt=0, in_ready=0, res_valid=0, res_data=0, res_core=0, cfg_err=0, busy=0, rr_ptr=0, accumulator=0, idx=0.
REQ-033 Reset SHALL clear all weights and bias to 0.
REQ-034 Reset mid-evaluation SHALL abort it without producing a result.

Verification
REQ-035 Weights all 1, bias 5, core 0 sends 1..9 back-to-back -> res_data=50, res_core=0, res_valid 11 cycles after req.
REQ-036 Weights all 127, inputs all 127 -> res_data=32767; weights all -128, inputs all 127 -> res_data=-32768.
REQ-037 req=4'b1111 held, res_ready=1 -> grants in order core 0,1,2,3,0; req=4'b0100 after core 2 served -> core 2 granted again.
REQ-038 res_ready low for 5 cycles in OUT -> res_valid and res_data held constant, no new grant; cfg_we in MAC -> cfg_err pulse, weights unchanged.
REQ-039 in_valid deasserted for 3 cycles mid-MAC -> result unchanged, res_valid delayed by 3 cycles.
REQ-040 rst_n low after 4 handshakes -> all outputs 0 immediately; weights 0; next evaluation of inputs 1..9 -> res_data=0.

Source files
------------

// File: rtl/fc_core_scheduler.sv
// Shared fully-connected MAC engine: round-robin arbitration among cores, serial
// N_TAPS-term multiply-accumulate with a writable weight/bias table, saturated result.
module fc_core_scheduler #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned N_TAPS    = 9
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        in_valid,
   input  logic [NUM_CORES*8-1:0]      in_data,
   output logic [NUM_CORES-1:0]        in_ready,
   output logic [NUM_CORES-1:0]        gnt,
   input  logic                        cfg_we,
   input  logic [3:0]                  cfg_addr,
   input  logic [7:0]                  cfg_wdata,
   output logic                        cfg_err,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic signed [15:0]          res_data,
   output logic [2:0]                  res_core,
   output logic                        busy
);

   localparam int unsigned CW = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 16;
   localparam int unsigned AW = 20;
   localparam int unsigned IW = 4;

   typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} state_t;

   state_t                  state_q, state_d;
   logic [NUM_CORES-1:0]    gnt_d, in_ready_d;
   logic [CW-1:0]           g_q, g_d, rr_q, rr_d, pick;
   logic [IW-1:0]           idx_q, idx_d;
   logic signed [AW-1:0]    acc_q, acc_d, acc_b;
   logic                    res_valid_d, cfg_err_d, busy_d, cfg_ok, found;
   logic signed [PW-1:0]    res_data_d, prod;
   logic [2:0]              res_core_d;
   logic signed [DW-1:0]    sample;
   logic signed [DW-1:0]    w_q [N_TAPS+1];
   int unsigned             j;

   // Next-state, datapath and output decode
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt;
      in_ready_d  = in_ready;
      g_d         = g_q;
      rr_d        = rr_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      res_valid_d = res_valid;
      res_data_d  = res_data;
      res_core_d  = res_core;
      pick        = '0;
      found       = 1'b0;
      j           = 0;

      // Round-robin search starting at rr_q
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         j = 32'(rr_q) + k;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = CW'(j);
         end
      end

      sample = in_data[DW*32'(g_q) +: DW];
      prod   = sample * w_q[idx_q];
      acc_b  = acc_q + $signed({{(AW-DW){w_q[N_TAPS][DW-1]}}, w_q[N_TAPS]});

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = MAC;
               g_d        = pick;
               gnt_d      = NUM_CORES'(1) << pick;
               in_ready_d = NUM_CORES'(1) << pick;
               acc_d      = '0;
               idx_d      = '0;
            end
         end
         MAC: begin
            if (in_valid[g_q] && in_ready[g_q]) begin
               acc_d = acc_q + $signed({{(AW-PW){prod[PW-1]}}, prod});
               idx_d = idx_q + IW'(1);
               if (idx_q == IW'(N_TAPS - 1)) begin
                  state_d    = BIAS;
                  in_ready_d = '0;
               end
            end
         end
         BIAS: begin
            acc_d       = acc_b;
            state_d     = OUT;
            res_valid_d = 1'b1;
            res_core_d  = 3'(g_q);
            if (acc_b > 20'sd32767)       res_data_d = 16'sh7fff;
            else if (acc_b < -20'sd32768) res_data_d = 16'sh8000;
            else                          res_data_d = acc_b[PW-1:0];
         end
         OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               gnt_d       = '0;
               rr_d        = (g_q == CW'(NUM_CORES - 1)) ? '0 : g_q + CW'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      cfg_ok    = cfg_we && (state_q == IDLE) && (cfg_addr <= IW'(N_TAPS));
      cfg_err_d = cfg_we && !cfg_ok;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt       <= '0;
         in_ready  <= '0;
         g_q       <= '0;
         rr_q      <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_core  <= '0;
         cfg_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt       <= gnt_d;
         in_ready  <= in_ready_d;
         g_q       <= g_d;
         rr_q      <= rr_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         res_valid <= res_valid_d;
         res_data  <= res_data_d;
         res_core  <= res_core_d;
         cfg_err   <= cfg_err_d;
         busy      <= busy_d;
      end
   end

   // Weight/bias table; writes land only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i <= N_TAPS; i++) w_q[i] <= '0;
      end else if (cfg_ok) begin
         w_q[cfg_addr] <= cfg_wdata;
      end
   end

endmodule

// File: tb/tb_fc_core_scheduler.sv
// Directed bench for fc_core_scheduler: latency, arithmetic, saturation, arbitration,
// backpressure, config rejection and reset abort.
module tb_fc_core_scheduler;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [3:0]         req, in_valid, in_ready, gnt;
   logic [31:0]        in_data;
   logic               cfg_we, cfg_err, res_valid, res_ready, busy;
   logic [3:0]         cfg_addr;
   logic [7:0]         cfg_wdata;
   logic signed [15:0] res_data;
   logic [2:0]         res_core;

   int n_checks = 0;
   int n_fail   = 0;
   logic signed [7:0] smp [9];

   fc_core_scheduler #(.NUM_CORES(4), .N_TAPS(9)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .gnt(gnt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_core(res_core), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int addr, input logic [7:0] data);
      cfg_we    = 1'b1;
      cfg_addr  = 4'(addr);
      cfg_wdata = data;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic set_weights(input logic [7:0] w, input logic [7:0] b);
      for (int i = 0; i < 9; i++) cfg_write(i, w);
      cfg_write(9, b);
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 9; i++) smp[i] = 8'(i + 1);
   endtask

   task automatic pulse_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   // Runs one evaluation until res_valid is seen; lat counts edges from req.
   task automatic do_eval(input logic [3:0] mask, input int core, input int stall_at,
                          input int stall_len, input bit poke,
                          output int lat, output logic [3:0] g1);
      int cnt, stalls;
      bit hs;
      cnt = 0; stalls = 0; lat = 0; g1 = '0;
      req = mask;
      while (res_valid !== 1'b1 && lat < 60) begin
         in_valid = '1;
         if (cnt == stall_at && stalls < stall_len && in_ready[core]) begin
            in_valid = '0;
            stalls++;
         end
         in_data = {4{(cnt < 9) ? smp[cnt] : 8'sd0}};
         hs = in_ready[core] && in_valid[core];
         if (poke && lat == 3) begin
            cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'd99;
         end
         tick();
         cfg_we = 1'b0;
         lat++;
         if (hs) cnt++;
         if (lat == 1) begin
            g1  = gnt;
            req = '0;
         end
         if (poke && lat == 4) begin
            n_checks++;
            if (cfg_err !== 1'b1) begin
               n_fail++;
               $display("FAIL cfg_err_in_mac: got %b expected 1", cfg_err);
            end
         end
      end
      in_valid = '0;
      if (res_valid !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL eval_timeout: res_valid=%b after %0d cycles", res_valid, lat);
      end
   endtask

   task automatic ack();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_checks++;
      if ({res_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL ack: res_valid,busy=%b expected 00", {res_valid, busy});
      end
   endtask

   task automatic check_result(input string name, input int lat, input int exp_lat,
                               input logic signed [15:0] exp_data, input logic [2:0] exp_core);
      n_checks++;
      if (lat !== exp_lat) begin
         n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (res_data !== exp_data) begin
         n_fail++; $display("FAIL %s_data: got %0d expected %0d", name, res_data, exp_data);
      end
      n_checks++;
      if (res_core !== exp_core) begin
         n_fail++; $display("FAIL %s_core: got %0d expected %0d", name, res_core, exp_core);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({gnt, in_ready, busy, res_valid, res_data, res_core, cfg_err} !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b in_ready=%b busy=%b res_valid=%b res_data=%0d res_core=%0d cfg_err=%b expected all 0",
                  gnt, in_ready, busy, res_valid, res_data, res_core, cfg_err);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_cfg_err();
      cfg_write(10, 8'd7);
      n_checks++;
      if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_addr: got %b expected 1", cfg_err); end
      tick();
      n_checks++;
      if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse: got %b expected 0", cfg_err); end
      cfg_write(9, 8'd0);
      n_checks++;
      if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_valid: got %b expected 0", cfg_err); end
   endtask

   task automatic test_basic();
      int lat; logic [3:0] g1;
      set_weights(8'd1, 8'd5);
      set_ramp();
      do_eval(4'b0001, 0, -1, 0, 1'b0, lat, g1);
      check_result("basic", lat, 11, 16'sd50, 3'd0);
      n_checks++;
      if ({g1, in_ready, res_valid} !== 9'b0001_0000_1) begin
         n_fail++; $display("FAIL basic_gnt: gnt=%b in_ready=%b res_valid=%b expected 0001 0000 1", g1, in_ready, res_valid);
      end
      ack();
   endtask

   task automatic test_stall();
      int lat; logic [3:0] g1;
      do_eval(4'b0001, 0, 4, 3, 1'b0, lat, g1);
      check_result("stall", lat, 14, 16'sd50, 3'd0);
      ack();
   endtask

   task automatic test_hold_out();
      int lat; logic [3:0] g1;
      do_eval(4'b0010, 1, -1, 0, 1'b0, lat, g1);
      check_result("hold", lat, 11, 16'sd50, 3'd1);
      req = 4'b0101;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if ({res_valid, res_data, gnt} !== {1'b1, 16'sd50, 4'b0010}) begin
            n_fail++;
            $display("FAIL hold_out_c%0d: res_valid=%b res_data=%0d gnt=%b expected 1 50 0010", c, res_valid, res_data, gnt);
         end
      end
      ack();
      tick();
      n_checks++;
      if (gnt !== 4'b0100) begin n_fail++; $display("FAIL held_req_gnt: got %b expected 0100", gnt); end
      do_eval(4'b0100, 2, -1, 0, 1'b0, lat, g1);
      check_result("held_req", lat, 10, 16'sd50, 3'd2);
      ack();
   endtask

   task automatic test_cfg_busy();
      int lat; logic [3:0] g1;
      do_eval(4'b0001, 0, -1, 0, 1'b1, lat, g1);
      check_result("cfg_busy", lat, 11, 16'sd50, 3'd0);
      ack();
      do_eval(4'b0001, 0, -1, 0, 1'b0, lat, g1);
      check_result("cfg_unchanged", lat, 11, 16'sd50, 3'd0);
      ack();
   endtask

   task automatic test_cfg_and_grant();
      int lat; logic [3:0] g1;
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'd3;
      do_eval(4'b0001, 0, -1, 0, 1'b0, lat, g1);
      check_result("cfg_and_grant", lat, 11, 16'sd52, 3'd0);
      ack();
      cfg_write(0, 8'd1);
   endtask

   task automatic test_round_robin();
      int lat; logic [3:0] g1;
      int exp_core [7] = '{0, 1, 2, 3, 0, 2, 2};
      pulse_reset();
      for (int n = 0; n < 7; n++) begin
         do_eval((n < 5) ? 4'b1111 : 4'b0100, exp_core[n], -1, 0, 1'b0, lat, g1);
         n_checks++;
         if (g1 !== 4'(1 << exp_core[n])) begin
            n_fail++; $display("FAIL rr_gnt_%0d: got %b expected core %0d", n, g1, exp_core[n]);
         end
         n_checks++;
         if (res_core !== 3'(exp_core[n])) begin
            n_fail++; $display("FAIL rr_core_%0d: got %0d expected %0d", n, res_core, exp_core[n]);
         end
         ack();
      end
   endtask

   task automatic test_saturate();
      int lat; logic [3:0] g1;
      for (int i = 0; i < 9; i++) smp[i] = 8'sd127;
      set_weights(8'd127, 8'd0);
      do_eval(4'b0001, 0, -1, 0, 1'b0, lat, g1);
      check_result("sat_pos", lat, 11, 16'sh7fff, 3'd0);
      ack();
      set_weights(8'h80, 8'd0);
      do_eval(4'b0001, 0, -1, 0, 1'b0, lat, g1);
      check_result("sat_neg", lat, 11, 16'sh8000, 3'd0);
      ack();
   endtask

   task automatic test_reset_mid();
      int lat; logic [3:0] g1;
      set_weights(8'd1, 8'd5);
      set_ramp();
      req = 4'b0001;
      in_valid = '1;
      tick();
      req = '0;
      for (int i = 0; i < 4; i++) begin
         in_data = {4{smp[i]}};
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({gnt, in_ready, busy, res_valid, res_data, res_core, cfg_err} !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: gnt=%b in_ready=%b busy=%b res_valid=%b res_data=%0d expected all 0",
                  gnt, in_ready, busy, res_valid, res_data);
      end
      in_valid = '0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      do_eval(4'b0001, 0, -1, 0, 1'b0, lat, g1);
      check_result("after_reset", lat, 11, 16'sd0, 3'd0);
      ack();
   endtask

   initial begin
      req = '0; in_valid = '0; in_data = '0; res_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      test_reset();
      test_cfg_err();
      test_basic();
      test_stall();
      test_hold_out();
      test_cfg_busy();
      test_cfg_and_grant();
      test_round_robin();
      test_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
